// File: rtl/fb_scanout_pkg.sv
// ---------------------------------------------------------------------------
// fb_scanout_pkg
// Shared framebuffer geometry, scanout FSM state encoding and the address
// helper used by the scanout datapath. The GPU uses the same framebuffer
// constants, so geometry lives here rather than inside the scanout module.
// No ports (package).
// ---------------------------------------------------------------------------
package fb_scanout_pkg;

    localparam logic [11:0] FB_BASE      = 12'h100;
    localparam int          FB_BYTES     = 256;
    localparam int          FB_ROW_BYTES = 8;
    localparam int          PAGES        = 8;
    localparam int          OLED_COLS    = 128;
    localparam int          PAGE_FETCH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One display page covers four framebuffer rows, i.e. 32 consecutive bytes,
    // so the byte address is simply base + {page, byte-within-page}.
    function automatic logic [11:0] fetchAddr(input logic [2:0] page,
                                              input logic [4:0] idx);
        return FB_BASE + {4'd0, page, idx};
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// ---------------------------------------------------------------------------
// fb_scanout_if
// Bundles the shared-memory read port and the SSD1306 byte stream.
//   mem_read / mem_read_idx      : read request and byte address
//   mem_read_byte / mem_read_ack : read data and completion strobe
//   out_valid / out_byte / out_first / out_ready : column byte stream
// master = scanout engine, slave = memory + display transmitter side.
// ---------------------------------------------------------------------------
interface fb_scanout_if;

    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;

    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_first;
    logic        out_ready;

    modport master (
        output mem_read, mem_read_idx, out_valid, out_byte, out_first,
        input  mem_read_byte, mem_read_ack, out_ready
    );

    modport slave (
        input  mem_read, mem_read_idx, out_valid, out_byte, out_first,
        output mem_read_byte, mem_read_ack, out_ready
    );

endinterface

// File: rtl/fb_scanout_column_pack.sv
// ---------------------------------------------------------------------------
// fb_column_pack
// Combinational re-packer: turns one 2x-scaled OLED column of the current
// page buffer into an SSD1306 column byte (LSB = top pixel).
//   i_pageBuf : 32 page-buffer bytes, byte k at bits [8k+7:8k]
//               (byte 8r + b = framebuffer row r of the page, byte b of row)
//   i_col     : OLED column 0..127
//   o_colByte : packed column byte, each source pixel occupies two bits
// ---------------------------------------------------------------------------
module fb_column_pack
    import fb_scanout_pkg::*;
(
    input  logic [8*PAGE_FETCH-1:0] i_pageBuf,
    input  logic [6:0]              i_col,
    output logic [7:0]              o_colByte
);

    logic [5:0] w_x;
    logic [3:0] w_pix;

    // Horizontal doubling: two adjacent OLED columns show the same source x.
    assign w_x = 6'(i_col >> 1);

    // Source bit index = 8*(8r + x/8) + (7 - x%8); the subtraction from 7 on a
    // 3-bit field is a plain inversion because the MSB is the leftmost pixel.
    for (genvar r = 0; r < 4; r++) begin : gPix
        localparam logic [1:0] ROW = 2'(r);
        assign w_pix[r] = i_pageBuf[{ROW, w_x[5:3], ~w_x[2:0]}];
    end

    // Vertical doubling: each source row fills two vertically adjacent bits.
    assign o_colByte = {{2{w_pix[3]}}, {2{w_pix[2]}}, {2{w_pix[1]}}, {2{w_pix[0]}}};

endmodule

// File: rtl/fb_scanout.sv
// ---------------------------------------------------------------------------
// fb_scanout
// Framebuffer scanout: on a refresh request reads the 64x32 monochrome
// framebuffer a page (32 bytes) at a time and streams 1024 SSD1306 column
// bytes with 2x scaling over a valid/ready handshake.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : refresh request, sampled only in IDLE
//   i_fb_write     : GPU write strobe (only with FB_SCANOUT_DIRTY_EN)
//   o_busy         : frame in progress
//   o_frame_done   : one-cycle pulse after the last byte is accepted
//   bus            : memory read port + output stream (fb_scanout_if.master)
// Optional feature macro: FB_SCANOUT_DIRTY_EN (skip refresh when unchanged).
// ---------------------------------------------------------------------------
module fb_scanout
    import fb_scanout_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
`ifdef FB_SCANOUT_DIRTY_EN
    input  logic i_fb_write,
`endif
    output logic o_busy,
    output logic o_frame_done,
    fb_scanout_if.master bus
);

    state_t       r_state,     w_nxtState;
    logic [2:0]   r_page,      w_nxtPage;
    logic [4:0]   r_fetchCnt,  w_nxtFetchCnt;
    logic [6:0]   r_col,       w_nxtCol;
    logic         r_busy,      w_nxtBusy;
    logic         r_frameDone, w_nxtFrameDone;
    logic         r_memRead,   w_nxtMemRead;
    logic [11:0]  r_memIdx,    w_nxtMemIdx;
    logic         r_outValid,  w_nxtOutValid;
    logic [7:0]   r_outByte,   w_nxtOutByte;
    logic         r_outFirst,  w_nxtOutFirst;
    logic [8*PAGE_FETCH-1:0] r_pageBuf;

    logic         w_accept;
    logic         w_capture;
    logic         w_dirty;
    logic [6:0]   w_packCol;
    logic [7:0]   w_packByte;

`ifdef FB_SCANOUT_DIRTY_EN
    logic r_dirty;

    // Dirty comes out of reset set so the very first refresh always scans; a
    // write landing in the same cycle as an accepted start keeps it set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dirty <= 1'b1;
        end else if (i_fb_write) begin
            r_dirty <= 1'b1;
        end else if (w_accept) begin
            r_dirty <= 1'b0;
        end
    end

    assign w_dirty = r_dirty;
`else
    assign w_dirty = 1'b1;
`endif

    // The packer always looks one column ahead so out_byte can be registered.
    assign w_packCol = (r_state == ST_EMIT) ? r_col + 7'd1 : 7'd0;

    fb_column_pack uPack (
        .i_pageBuf (r_pageBuf),
        .i_col     (w_packCol),
        .o_colByte (w_packByte)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_nxtState     = r_state;
        w_nxtPage      = r_page;
        w_nxtFetchCnt  = r_fetchCnt;
        w_nxtCol       = r_col;
        w_nxtBusy      = r_busy;
        w_nxtFrameDone = 1'b0;
        w_nxtMemRead   = r_memRead;
        w_nxtMemIdx    = r_memIdx;
        w_nxtOutValid  = r_outValid;
        w_nxtOutByte   = r_outByte;
        w_nxtOutFirst  = r_outFirst;
        w_accept       = 1'b0;
        w_capture      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && w_dirty) begin
                    w_accept      = 1'b1;
                    w_nxtState    = ST_FETCH;
                    w_nxtPage     = 3'd0;
                    w_nxtFetchCnt = 5'd0;
                    w_nxtBusy     = 1'b1;
                    w_nxtMemRead  = 1'b1;
                    w_nxtMemIdx   = fetchAddr(3'd0, 5'd0);
                end
            end

            ST_FETCH: begin
                if (r_memRead && bus.mem_read_ack) begin
                    w_capture = 1'b1;
                    if (r_fetchCnt == 5'(PAGE_FETCH - 1)) begin
                        // Column 0 only needs bytes 0/8/16/24, all already in
                        // the buffer, so byte 31 arriving now is not needed yet.
                        w_nxtMemRead  = 1'b0;
                        w_nxtState    = ST_EMIT;
                        w_nxtCol      = 7'd0;
                        w_nxtOutValid = 1'b1;
                        w_nxtOutByte  = w_packByte;
                        w_nxtOutFirst = (r_page == 3'd0);
                    end else begin
                        w_nxtFetchCnt = r_fetchCnt + 5'd1;
                        w_nxtMemIdx   = fetchAddr(r_page, r_fetchCnt + 5'd1);
                    end
                end
            end

            ST_EMIT: begin
                if (r_outValid && bus.out_ready) begin
                    if (r_col == 7'(OLED_COLS - 1)) begin
                        w_nxtOutValid = 1'b0;
                        w_nxtOutByte  = 8'd0;
                        w_nxtOutFirst = 1'b0;
                        if (r_page == 3'(PAGES - 1)) begin
                            w_nxtState     = ST_DONE;
                            w_nxtBusy      = 1'b0;
                            w_nxtFrameDone = 1'b1;
                        end else begin
                            w_nxtState    = ST_FETCH;
                            w_nxtPage     = r_page + 3'd1;
                            w_nxtFetchCnt = 5'd0;
                            w_nxtMemRead  = 1'b1;
                            w_nxtMemIdx   = fetchAddr(r_page + 3'd1, 5'd0);
                        end
                    end else begin
                        w_nxtCol      = r_col + 7'd1;
                        w_nxtOutByte  = w_packByte;
                        w_nxtOutFirst = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                // frame_done is high during this cycle; start here is dropped.
                w_nxtState = ST_IDLE;
            end

            default: begin
                w_nxtState = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_page      <= 3'd0;
            r_fetchCnt  <= 5'd0;
            r_col       <= 7'd0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_memRead   <= 1'b0;
            r_memIdx    <= 12'd0;
            r_outValid  <= 1'b0;
            r_outByte   <= 8'd0;
            r_outFirst  <= 1'b0;
        end else begin
            r_state     <= w_nxtState;
            r_page      <= w_nxtPage;
            r_fetchCnt  <= w_nxtFetchCnt;
            r_col       <= w_nxtCol;
            r_busy      <= w_nxtBusy;
            r_frameDone <= w_nxtFrameDone;
            r_memRead   <= w_nxtMemRead;
            r_memIdx    <= w_nxtMemIdx;
            r_outValid  <= w_nxtOutValid;
            r_outByte   <= w_nxtOutByte;
            r_outFirst  <= w_nxtOutFirst;
        end
    end

    // Page buffer holds no control state, so it is left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_pageBuf[{r_fetchCnt, 3'b000} +: 8] <= bus.mem_read_byte;
        end
    end

    assign o_busy           = r_busy;
    assign o_frame_done     = r_frameDone;
    assign bus.mem_read     = r_memRead;
    assign bus.mem_read_idx = r_memIdx;
    assign bus.out_valid    = r_outValid;
    assign bus.out_byte     = r_outByte;
    assign bus.out_first    = r_outFirst;

endmodule

// File: tb/tb_fb_scanout.sv
// ---------------------------------------------------------------------------
// tb_fb_scanout
// Scoreboard bench for fb_scanout: a memory responder serves reads from a
// local framebuffer image, stimulus pushes the expected 1024-byte stream, and
// a monitor pops and compares every byte the DUT presents.
// ---------------------------------------------------------------------------
module tb_fb_scanout;
    import fb_scanout_pkg::*;

    typedef struct {
        logic [7:0] b;
        logic       first;
    } expItem_t;

    logic clk = 1'b0;
    logic rstN;
    logic start;
    logic fbWrite;
    logic busy;
    logic frameDone;

    fb_scanout_if bus ();

    fb_scanout dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_start      (start),
`ifdef FB_SCANOUT_DIRTY_EN
        .i_fb_write   (fbWrite),
`endif
        .o_busy       (busy),
        .o_frame_done (frameDone),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem      [0:4095];
    logic [7:0] expBytes [0:1023];
    expItem_t   expQ     [$];

    int compareCount = 0;
    int mismatchCount = 0;
    int readCount = 0;
    int doneCount = 0;
    int byteIdx = 0;
    int ackDelay = 0;
    int waitCnt = 0;
    bit stallMode = 1'b0;
    bit sawRead = 1'b0;

    // Single place where every comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Memory responder: acks after 1..3 cycles in stall mode, else 1 cycle,
    // and checks that reads walk the framebuffer in ascending order.
    initial begin
        bus.mem_read_ack  = 1'b0;
        bus.mem_read_byte = 8'd0;
        forever begin
            @(negedge clk);
            bus.mem_read_ack = 1'b0;
            if (rstN === 1'b1 && bus.mem_read === 1'b1) begin
                sawRead = 1'b1;
                if (waitCnt >= ackDelay) begin
                    checkOutput($sformatf("readAddr[%0d]", readCount),
                                32'(bus.mem_read_idx), 32'(FB_BASE) + readCount);
                    bus.mem_read_byte = mem[bus.mem_read_idx];
                    bus.mem_read_ack  = 1'b1;
                    readCount++;
                    waitCnt  = 0;
                    ackDelay = stallMode ? $urandom_range(2, 0) : 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Downstream ready: always ready, or a coin toss per cycle in stall mode.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = stallMode ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Monitor: compares the presented byte with the queue head every valid
    // cycle (so stalled bytes must stay put) and pops on a handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstN === 1'b1) begin
                if (frameDone === 1'b1) doneCount++;
                if (bus.out_valid === 1'b1) begin
                    if (expQ.size() == 0) begin
                        compareCount++;
                        mismatchCount++;
                        $display("[TB] FAIL extraByte: got 0x%0h, want no byte", bus.out_byte);
                    end else begin
                        checkOutput($sformatf("outByte[%0d]", byteIdx), 32'(bus.out_byte), 32'(expQ[0].b));
                        checkOutput($sformatf("outFirst[%0d]", byteIdx), 32'(bus.out_first), 32'(expQ[0].first));
                        if (bus.out_ready === 1'b1) begin
                            void'(expQ.pop_front());
                            byteIdx++;
                        end
                    end
                end
            end
        end
    end

    task automatic clearFb();
        for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
        for (int i = 0; i < 1024; i++) expBytes[i] = 8'd0;
    endtask

    // Reference packing written straight from pixel coordinates (x, y).
    task automatic buildModel();
        for (int i = 0; i < 1024; i++) begin
            int p;
            int x;
            logic [7:0] b;
            logic [7:0] src;
            p = i / 128;
            x = (i % 128) / 2;
            b = 8'd0;
            for (int r = 0; r < 4; r++) begin
                src = mem[32'(FB_BASE) + (4 * p + r) * FB_ROW_BYTES + x / 8];
                b[2 * r]     = src[7 - x % 8];
                b[2 * r + 1] = src[7 - x % 8];
            end
            expBytes[i] = b;
        end
    endtask

    task automatic pushExpected();
        byteIdx = 0;
        for (int i = 0; i < 1024; i++) expQ.push_back('{b: expBytes[i], first: (i == 0)});
    endtask

    task automatic pulseStart(input string tag, input bit doWrite);
        readCount = 0;
        doneCount = 0;
        if (doWrite) begin
            @(negedge clk);
            fbWrite = 1'b1;
            @(negedge clk);
            fbWrite = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        checkOutput({tag, ".busyAfterStart"}, 32'(busy), 32'd1);
        checkOutput({tag, ".memReadAfterStart"}, 32'(bus.mem_read), 32'd1);
        checkOutput({tag, ".firstIdx"}, 32'(bus.mem_read_idx), 32'(FB_BASE));
    endtask

    task automatic waitFrameDone(input string tag);
        int cycles;
        cycles = 0;
        while (frameDone !== 1'b1 && cycles < 20000) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        if (cycles >= 20000) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL %s.timeout: got no frame_done, want frame_done within 20000 cycles", tag);
        end else begin
            checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd0);
            @(negedge clk);
            #2;
            checkOutput({tag, ".donePulseWidth"}, 32'(frameDone), 32'd0);
            repeat (4) @(negedge clk);
            #2;
            checkOutput({tag, ".doneCount"}, 32'(doneCount), 32'd1);
            checkOutput({tag, ".readCount"}, 32'(readCount), 32'(FB_BYTES));
            checkOutput({tag, ".bytesLeft"}, 32'(expQ.size()), 32'd0);
            checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit doWrite);
        pushExpected();
        pulseStart(tag, doWrite);
        waitFrameDone(tag);
    endtask

    initial begin
        rstN    = 1'b0;
        start   = 1'b0;
        fbWrite = 1'b0;
        clearFb();

        // Reset with random inputs: every output must read zero.
        stallMode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start   = 1'($urandom_range(1, 0));
            fbWrite = 1'($urandom_range(1, 0));
            #2;
            checkOutput($sformatf("resetOutputs[%0d]", i),
                        {8'd0, busy, frameDone, bus.mem_read, bus.mem_read_idx,
                         bus.out_valid, bus.out_byte, bus.out_first}, 32'd0);
        end
        @(negedge clk);
        start     = 1'b0;
        fbWrite   = 1'b0;
        stallMode = 1'b0;
        @(negedge clk);
        rstN    = 1'b1;
        sawRead = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        checkOutput("noReadWithoutStart", 32'(sawRead), 32'd0);
        checkOutput("idleBusyAfterReset", 32'(busy), 32'd0);

        // All-zero framebuffer; first frame scans without a write.
        $display("[TB] frame: all zero");
        applyStimulus("zero", 1'b0);

        $display("[TB] frame: top-left pixel");
        clearFb();
        mem[12'h100] = 8'h80;
        expBytes[0] = 8'h03;
        expBytes[1] = 8'h03;
        applyStimulus("topLeft", 1'b1);

        $display("[TB] frame: bottom-right pixel");
        clearFb();
        mem[12'h1FF] = 8'h01;
        expBytes[1022] = 8'hC0;
        expBytes[1023] = 8'hC0;
        applyStimulus("bottomRight", 1'b1);

        $display("[TB] frame: sprite row");
        clearFb();
        mem[12'h100] = 8'hFF;
        for (int i = 0; i < 16; i++) expBytes[i] = 8'h03;
        applyStimulus("spriteRow", 1'b1);

        $display("[TB] frame: column of four plus page 1 pixel");
        clearFb();
        mem[12'h100] = 8'h80;
        mem[12'h108] = 8'h80;
        mem[12'h110] = 8'h80;
        mem[12'h118] = 8'h80;
        mem[12'h120] = 8'h01;
        expBytes[0]   = 8'hFF;
        expBytes[1]   = 8'hFF;
        expBytes[142] = 8'h03;
        expBytes[143] = 8'h03;
        applyStimulus("column", 1'b1);

        // Dense pattern, first at full rate, then with stalls and a start
        // pulse mid-frame that must not queue a second frame.
        clearFb();
        for (int i = 0; i < 256; i++) mem[256 + i] = 8'(i * 29 + 7);
        buildModel();
        $display("[TB] frame: pattern, no stalls");
        applyStimulus("pattern", 1'b1);

        $display("[TB] frame: pattern, stalls");
        stallMode = 1'b1;
        fork
            begin
                repeat (300) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        applyStimulus("patternStall", 1'b1);

        // Reset mid-frame: outputs drop asynchronously, next frame is clean.
        $display("[TB] frame: reset mid-frame");
        pushExpected();
        pulseStart("abort", 1'b1);
        repeat (150) @(negedge clk);
        #2;
        checkOutput("abort.busyBeforeReset", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("abort.memReadDrop", 32'(bus.mem_read), 32'd0);
        checkOutput("abort.outValidDrop", 32'(bus.out_valid), 32'd0);
        checkOutput("abort.busyDrop", 32'(busy), 32'd0);
        expQ.delete();
        @(negedge clk);
        stallMode = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("afterAbort", 1'b1);

`ifdef FB_SCANOUT_DIRTY_EN
        // Clean framebuffer: start is ignored until the GPU writes again.
        $display("[TB] dirty flag: start without write");
        readCount = 0;
        doneCount = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        checkOutput("clean.busy", 32'(busy), 32'd0);
        checkOutput("clean.readCount", 32'(readCount), 32'd0);
        checkOutput("clean.doneCount", 32'(doneCount), 32'd0);
        applyStimulus("dirtyAgain", 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
